// File: rtl/mem_ctrl_ram.sv
// Single-port synchronous RAM with valid/ready requests, byte-lane writes,
// a configurable fully pipelined read latency and a post-reset clear sequencer.
module mem_ctrl_ram #(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    ADDR_WIDTH = 8,
    parameter int                    MEM_DEPTH  = 256,
    parameter int                    RD_LATENCY = 1,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0,
    parameter int                    BE_WIDTH   = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [BE_WIDTH-1:0]   req_be,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  init_done,
    output logic                  err_addr
);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] CNT_ONE   = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   DEPTH_W   = (ADDR_WIDTH + 1)'(MEM_DEPTH);

    logic [DATA_WIDTH-1:0] mem_r [0:MEM_DEPTH-1];

    state_t                state_r;
    logic [ADDR_WIDTH-1:0] cnt_r;
    logic                  req_ready_r;
    logic                  init_done_r;
    logic                  err_addr_r;

    logic [RD_LATENCY-1:0] vld_r;
    logic [DATA_WIDTH-1:0] dat_r [RD_LATENCY];

    logic                  in_range_s;
    logic                  acc_s;
    logic                  wr_acc_s;
    logic                  rd_acc_s;
    logic [DATA_WIDTH-1:0] rd_word_s;

    // Request qualification and the word sampled by an accepted read.
    always_comb begin
        in_range_s = ({1'b0, req_addr} < DEPTH_W);
        acc_s      = req_valid && req_ready_r;
        wr_acc_s   = acc_s && req_we && in_range_s;
        rd_acc_s   = acc_s && !req_we;
        rd_word_s  = '0;
        if (in_range_s) begin
            rd_word_s = mem_r[req_addr];
        end else begin
            rd_word_s = '0;
        end
    end

    // Storage array: cleared word by word during INIT, byte-lane writes in RUN.
    always_ff @(posedge clk) begin
        if (state_r == ST_INIT) begin
            mem_r[cnt_r] <= INIT_VALUE;
        end else if (wr_acc_s) begin
            for (int i = 0; i < BE_WIDTH; i++) begin
                if (req_be[i]) begin
                    mem_r[req_addr][8*i +: 8] <= req_wdata[8*i +: 8];
                end
            end
        end
    end

    // Init/run sequencer with registered handshake and sticky address error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_INIT;
            cnt_r       <= '0;
            req_ready_r <= 1'b0;
            init_done_r <= 1'b0;
            err_addr_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_INIT: begin
                    cnt_r <= cnt_r + CNT_ONE;
                    if (cnt_r == LAST_ADDR) begin
                        state_r     <= ST_RUN;
                        req_ready_r <= 1'b1;
                        init_done_r <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (acc_s && !in_range_s) begin
                        err_addr_r <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= ST_INIT;
                    cnt_r       <= '0;
                    req_ready_r <= 1'b0;
                    init_done_r <= 1'b0;
                end
            endcase
        end
    end

    // Read pipeline; each data stage only advances behind a valid, so the
    // last stage doubles as the hold register for rsp_rdata.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_r <= '0;
            for (int k = 0; k < RD_LATENCY; k++) begin
                dat_r[k] <= '0;
            end
        end else begin
            vld_r[0] <= rd_acc_s;
            if (rd_acc_s) begin
                dat_r[0] <= rd_word_s;
            end
            for (int k = 1; k < RD_LATENCY; k++) begin
                vld_r[k] <= vld_r[k-1];
                if (vld_r[k-1]) begin
                    dat_r[k] <= dat_r[k-1];
                end
            end
        end
    end

    assign req_ready = req_ready_r;
    assign init_done = init_done_r;
    assign err_addr  = err_addr_r;
    assign rsp_valid = vld_r[RD_LATENCY-1];
    assign rsp_rdata = dat_r[RD_LATENCY-1];

endmodule

// File: tb/tb_mem_ctrl_ram.sv
// Scoreboard bench for mem_ctrl_ram: 16-bit words, 200-entry array,
// read latency 3, init pattern A5A5.
module tb_mem_ctrl_ram;

    localparam int DW     = 16;
    localparam int AW     = 8;
    localparam int DEPTH  = 200;
    localparam int RD_LAT = 3;

    typedef struct {
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic [1:0]    req_be;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          init_done;
    logic          err_addr;

    int   edge_cnt = 0;
    int   n_cmp    = 0;
    int   n_err    = 0;
    int   init_len;
    exp_t sb_q[$];
    exp_t mon_e;

    mem_ctrl_ram #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .MEM_DEPTH  (DEPTH),
        .RD_LATENCY (RD_LAT),
        .INIT_VALUE (16'hA5A5)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .init_done (init_done),
        .err_addr  (err_addr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Response monitor: every pulse must match the head of the scoreboard at
    // exactly its expected cycle; overdue entries count as missing responses.
    always @(negedge clk) begin
        if (rsp_valid) begin
            if (sb_q.size() == 0) begin
                check_val("rsp_spurious", {31'd0, rsp_valid}, 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                check_val("rsp_data", {16'd0, rsp_rdata}, {16'd0, mon_e.data});
                check_val("rsp_cycle", edge_cnt, mon_e.cyc);
            end
        end else if (sb_q.size() > 0 && edge_cnt > sb_q[0].cyc) begin
            check_val("rsp_missing", 32'd0, 32'd1);
            mon_e = sb_q.pop_front();
        end
    end

    task automatic drive_req(input logic we, input logic [AW-1:0] addr,
                             input logic [DW-1:0] wdata, input logic [1:0] be,
                             input logic [DW-1:0] exp);
        exp_t e;
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = be;
        if (!we) begin
            e.data = exp;
            e.cyc  = edge_cnt + RD_LAT;
            sb_q.push_back(e);
        end
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        idle_cycle();
        n = 0;
        while (sb_q.size() > 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check_val("drain", sb_q.size(), 32'd0);
    endtask

    task automatic wait_init(output int k);
        k = 0;
        while (k < 400) begin
            @(negedge clk);
            k++;
            if (req_ready) begin
                req_valid = 1'b0;
                break;
            end
        end
        req_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_be    = 2'b00;
        repeat (3) @(negedge clk);
        check_val("rst_ready", {31'd0, req_ready}, 32'd0);
        check_val("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check_val("rst_rdata", {16'd0, rsp_rdata}, 32'd0);
        check_val("rst_init_done", {31'd0, init_done}, 32'd0);
        check_val("rst_err_addr", {31'd0, err_addr}, 32'd0);

        // Hold a write to addr 5 pending during INIT; it must be ignored.
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 8'd5;
        req_wdata = 16'h0000;
        req_be    = 2'b11;
        rst_n     = 1'b1;
        wait_init(init_len);
        check_val("init_len", init_len, DEPTH);
        check_val("init_done", {31'd0, init_done}, 32'd1);

        drive_req(1'b0, 8'd0,   16'h0000, 2'b00, 16'hA5A5);
        drive_req(1'b0, 8'd99,  16'h0000, 2'b00, 16'hA5A5);
        drive_req(1'b0, 8'd199, 16'h0000, 2'b00, 16'hA5A5);
        drive_req(1'b0, 8'd5,   16'h0000, 2'b00, 16'hA5A5);
        drain();

        // Byte-lane writes, interleaved with reads.
        drive_req(1'b1, 8'd3, 16'h1234, 2'b01, 16'h0000);
        drive_req(1'b0, 8'd3, 16'h0000, 2'b00, 16'hA534);
        drive_req(1'b1, 8'd3, 16'hBEEF, 2'b10, 16'h0000);
        drive_req(1'b0, 8'd3, 16'h0000, 2'b00, 16'hBE34);
        drive_req(1'b1, 8'd3, 16'hFFFF, 2'b00, 16'h0000);
        drive_req(1'b0, 8'd3, 16'h0000, 2'b00, 16'hBE34);
        drain();
        repeat (3) @(negedge clk);
        check_val("rdata_hold", {16'd0, rsp_rdata}, 32'h0000BE34);

        // Pipelined back-to-back reads at latency 3.
        drive_req(1'b1, 8'd0, 16'h0011, 2'b11, 16'h0000);
        drive_req(1'b1, 8'd1, 16'h0022, 2'b11, 16'h0000);
        drive_req(1'b1, 8'd2, 16'h0033, 2'b11, 16'h0000);
        drive_req(1'b0, 8'd0, 16'h0000, 2'b00, 16'h0011);
        drive_req(1'b0, 8'd1, 16'h0000, 2'b00, 16'h0022);
        drive_req(1'b0, 8'd2, 16'h0000, 2'b00, 16'h0033);
        drain();

        // Read immediately after write to the same address.
        drive_req(1'b1, 8'd7, 16'h0055, 2'b11, 16'h0000);
        drive_req(1'b0, 8'd7, 16'h0000, 2'b00, 16'h0055);
        drain();
        check_val("err_before_oor", {31'd0, err_addr}, 32'd0);

        // Out-of-range write and read; aliases of 250 must keep their data.
        drive_req(1'b1, 8'd250, 16'h00FF, 2'b11, 16'h0000);
        idle_cycle();
        check_val("err_after_oor_wr", {31'd0, err_addr}, 32'd1);
        drive_req(1'b0, 8'd250, 16'h0000, 2'b00, 16'h0000);
        drive_req(1'b0, 8'd50,  16'h0000, 2'b00, 16'hA5A5);
        drive_req(1'b0, 8'd122, 16'h0000, 2'b00, 16'hA5A5);
        drive_req(1'b0, 8'd7,   16'h0000, 2'b00, 16'h0055);
        drain();
        repeat (5) @(negedge clk);
        check_val("err_sticky", {31'd0, err_addr}, 32'd1);

        // Reset while reads are in flight.
        drive_req(1'b0, 8'd0, 16'h0000, 2'b00, 16'h0011);
        drive_req(1'b0, 8'd1, 16'h0000, 2'b00, 16'h0022);
        drive_req(1'b0, 8'd2, 16'h0000, 2'b00, 16'h0033);
        @(negedge clk);
        #2;
        req_valid = 1'b0;
        rst_n     = 1'b0;
        sb_q.delete();
        #1;
        check_val("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check_val("midrst_init_done", {31'd0, init_done}, 32'd0);
        check_val("midrst_err_addr", {31'd0, err_addr}, 32'd0);
        check_val("midrst_ready", {31'd0, req_ready}, 32'd0);
        repeat (4) @(negedge clk);
        check_val("midrst_rdata", {16'd0, rsp_rdata}, 32'd0);
        rst_n = 1'b1;
        wait_init(init_len);
        check_val("reinit_len", init_len, DEPTH);
        check_val("reinit_err_addr", {31'd0, err_addr}, 32'd0);
        drive_req(1'b0, 8'd0, 16'h0000, 2'b00, 16'hA5A5);
        drive_req(1'b0, 8'd2, 16'h0000, 2'b00, 16'hA5A5);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
